// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and default sizing for the mux scan controller
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_CH_DEF     = 16;
    localparam int SEL_W_DEF      = 4;
    localparam int SETTLE_CYC_DEF = 1;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// rtl/mux_scan_settle_cnt.sv - per-channel settle counter, terminal count when count equals SETTLE_CYC
module mux_scan_settle_cnt
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [3:0] TC_VAL = 4'(SETTLE_CYC);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Wrap on terminal count so the next channel starts settling from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a NUM_CH:1 bit mux into a parallel word with valid/ready; MUX_SCAN_CONT_EN selects continuous rescanning
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_bit,
    output logic [NUM_CH-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0] acc_next;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              tc;

    mux_scan_settle_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != SCAN),
        .en_i  (state_q == SCAN),
        .tc_o  (tc)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        data_d   = data_q;
        valid_d  = valid_q;
        acc_next = acc_q;
        acc_next[sel_q] = mux_bit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    acc_d   = '0;
                end
            end
            SCAN: begin
                if (tc) begin
                    acc_d = acc_next;
                    // The last channel's bit goes straight into the output word.
                    if (sel_q == LAST_SEL) begin
                        data_d  = acc_next;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
`ifdef MUX_SCAN_CONT_EN
                    state_d = SCAN;
                    acc_d   = '0;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign mux_sel  = sel_q;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl at settle 1, 0 and 3
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start0, ready0, valid0, busy0;
    logic [3:0]  sel0;
    logic [15:0] dout0, in0;
    logic        bit0;

    logic        start1, ready1, valid1, busy1;
    logic [3:0]  sel1;
    logic [15:0] dout1, in1;
    logic        bit1;

    logic        start2, ready2, valid2, busy2;
    logic [3:0]  sel2;
    logic [15:0] dout2, in2;
    logic        bit2;

    // 16:1 bit-select mux feeding each controller
    assign bit0 = in0[sel0];
    assign bit1 = in1[sel1];
    assign bit2 = in2[sel2];

    mux_scan_ctrl #(.NUM_CH(16), .SEL_W(4), .SETTLE_CYC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mux_sel(sel0), .mux_bit(bit0),
        .data_out(dout0), .valid(valid0), .ready(ready0), .busy(busy0)
    );

    mux_scan_ctrl #(.NUM_CH(16), .SEL_W(4), .SETTLE_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mux_sel(sel1), .mux_bit(bit1),
        .data_out(dout1), .valid(valid1), .ready(ready1), .busy(busy1)
    );

    mux_scan_ctrl #(.NUM_CH(16), .SEL_W(4), .SETTLE_CYC(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mux_sel(sel2), .mux_bit(bit2),
        .data_out(dout2), .valid(valid2), .ready(ready2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [15:0] word;
        int          wait_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name, input logic [15:0] act);
        logic [15:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h with empty scoreboard", name, act);
        end else begin
            exp = sb_q.pop_front();
            check(name, act, exp);
        end
    endtask

    task automatic check_reset0();
        check("rst_sel", sel0, 0);
        check("rst_data", dout0, 0);
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
    endtask

    task automatic scan0(input logic [15:0] word, input int wait_cyc);
        int cyc;
        in0    = word;
        ready0 = (wait_cyc == 0);
        start0 = 1'b1;
        sb_q.push_back(word);
        tick();
        start0 = 1'b0;
        check("busy_after_start", busy0, 1);
        cyc = 0;
        while (!valid0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("latency", cyc, 32);
        for (int i = 0; i < wait_cyc; i++) begin
            check("hold_valid", valid0, 1);
            check("hold_data", dout0, word);
            start0 = i[0];
            tick();
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        check("valid_high", valid0, 1);
        pop_check("word", dout0);
        tick();
        ready0 = 1'b0;
        check("valid_drop", valid0, 0);
        check("busy_idle", busy0, 0);
        check("sel_zero", sel0, 0);
        check("data_kept", dout0, word);
        tick();
        check("stay_idle", busy0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{word: 16'hA5C3, wait_cyc: 0};
        vecs[1] = '{word: 16'h8001, wait_cyc: 10};
        vecs[2] = '{word: 16'h0F0F, wait_cyc: 3};
        vecs[3] = '{word: 16'h0000, wait_cyc: 0};
        vecs[4] = '{word: 16'hFFFF, wait_cyc: 1};

        rst_n  = 1'b0;
        start0 = 1'b0; ready0 = 1'b0; in0 = '0;
        start1 = 1'b0; ready1 = 1'b0; in1 = '0;
        start2 = 1'b0; ready2 = 1'b0; in2 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset0();

`ifdef MUX_SCAN_CONT_EN
        in0    = 16'h00FF;
        ready0 = 1'b1;
        start0 = 1'b1;
        for (int k = 0; k < 3; k++) sb_q.push_back(16'h00FF);
        tick();
        start0 = 1'b0;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            while (!valid0 && cyc < 200) begin
                tick();
                cyc++;
            end
            check("cont_interval", cyc, (k == 0) ? 32 : 33);
            pop_check("cont_word", dout0);
            tick();
            cyc = 1;
            check("cont_valid_drop", valid0, 0);
            check("cont_busy", busy0, 1);
        end
`else
        for (int v = 0; v < 5; v++) begin
            scan0(vecs[v].word, vecs[v].wait_cyc);
        end

        // Zero settle: one channel per edge
        in1    = 16'hFFFF;
        ready1 = 1'b1;
        start1 = 1'b1;
        sb_q.push_back(16'hFFFF);
        tick();
        start1 = 1'b0;
        check("s0_sel_start", sel1, 0);
        for (int n = 1; n < 16; n++) begin
            tick();
            check("s0_sel_step", sel1, n);
            check("s0_no_valid", valid1, 0);
        end
        tick();
        check("s0_valid", valid1, 1);
        pop_check("s0_word", dout1);
        tick();
        check("s0_valid_drop", valid1, 0);
        ready1 = 1'b0;

        // Only the sample edge of channel 5 sees the disturbance
        in2    = 16'hFFFF;
        ready2 = 1'b1;
        start2 = 1'b1;
        sb_q.push_back(16'hFFDF);
        tick();
        start2 = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            tick();
            if (n == 21) begin
                check("s3_sel5", sel2, 5);
                in2 = 16'h0000;
            end
            if (n == 24) in2 = 16'hFFFF;
            if (n == 63) check("s3_no_valid", valid2, 0);
        end
        check("s3_valid", valid2, 1);
        pop_check("s3_word", dout2);
        tick();
        check("s3_valid_drop", valid2, 0);
        ready2 = 1'b0;
`endif

        // Reset in the middle of a scan discards the partial word
        in0    = 16'hFFFF;
        ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 1; n < 9; n++) tick();
        check("mid_busy", busy0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset0();
        tick();
        check("post_rst_idle", busy0, 0);
`ifndef MUX_SCAN_CONT_EN
        scan0(16'h1234, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
